// File: rtl/fadd_pkg.sv
// Shared types and constants for the single-precision adder stream driver.
package fadd_pkg;

  localparam int unsigned FLOAT_W            = 32;
  localparam int unsigned FIFO_DEPTH_DEFAULT = 4;

  typedef enum logic [2:0] {
    RST_HI,
    RST_LO,
    IDLE,
    SEND_A,
    SEND_B,
    WAIT_Z
  } fadd_state_e;

  typedef struct packed {
    logic [FLOAT_W-1:0] a;
    logic [FLOAT_W-1:0] b;
  } operand_pair_t;

endpackage

// File: rtl/fadd_operand_fifo.sv
// Operand-pair FIFO; depth must be a power of two so the pointers wrap naturally.
module fadd_operand_fifo
  import fadd_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  operand_pair_t wr_data,
  input  logic          pop,
  output operand_pair_t rd_data,
  output logic          empty,
  output logic          full
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  operand_pair_t    mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  // A full FIFO refuses a push even when a pop frees a slot in the same cycle.
  assign full    = (count == CNT_W'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (do_push && !do_pop)      count <= count + CNT_W'(1);
      else if (!do_push && do_pop) count <= count - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/fadd_stream_driver.sv
// Streams queued operand pairs through a strobe/ack float adder core and
// presents results on a valid/ready output with a delivered-result counter.
module fadd_stream_driver
  import fadd_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [FLOAT_W-1:0] in_a,
  input  logic [FLOAT_W-1:0] in_b,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [FLOAT_W-1:0] out_z,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               fadd_rst,
  output logic [FLOAT_W-1:0] fadd_input_a,
  output logic               fadd_input_a_stb,
  input  logic               fadd_input_a_ack,
  output logic [FLOAT_W-1:0] fadd_input_b,
  output logic               fadd_input_b_stb,
  input  logic               fadd_input_b_ack,
  input  logic [FLOAT_W-1:0] fadd_output_z,
  input  logic               fadd_output_z_stb,
  output logic               fadd_output_z_ack,
  output logic               busy,
  output logic [15:0]        done_count
);

  localparam int unsigned DONE_W = 16;

  fadd_state_e        state_q, state_d;
  logic [FLOAT_W-1:0] op_a_q, op_a_d;
  logic [FLOAT_W-1:0] op_b_q, op_b_d;
  logic               fadd_rst_d;
  logic [FLOAT_W-1:0] input_a_d, input_b_d;
  logic               input_a_stb_d, input_b_stb_d;
  logic [FLOAT_W-1:0] out_z_d;
  logic               out_valid_d;
  logic [DONE_W-1:0]  done_count_d;

  operand_pair_t      in_pair;
  operand_pair_t      head;
  logic               fifo_empty;
  logic               fifo_full;
  logic               push;
  logic               pop;
  logic               drain;
  logic               z_take;

  assign in_pair  = '{a: in_a, b: in_b};
  assign in_ready = !fifo_full && (state_q != RST_HI) && (state_q != RST_LO);
  assign push     = in_valid && in_ready;
  assign drain    = out_valid && out_ready;
  // Result is only taken when the output register is free or draining now.
  assign z_take   = !rst && (state_q == WAIT_Z) && fadd_output_z_stb &&
                    (!out_valid || out_ready);
  assign fadd_output_z_ack = z_take;
  assign busy     = (state_q != IDLE) || !fifo_empty;

  fadd_operand_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .wr_data (in_pair),
    .pop     (pop),
    .rd_data (head),
    .empty   (fifo_empty),
    .full    (fifo_full)
  );

  // Next-state and next-output logic; core strobes and data are zero unless sending.
  always_comb begin
    state_d       = state_q;
    op_a_d        = op_a_q;
    op_b_d        = op_b_q;
    fadd_rst_d    = 1'b0;
    input_a_d     = '0;
    input_a_stb_d = 1'b0;
    input_b_d     = '0;
    input_b_stb_d = 1'b0;
    out_z_d       = out_z;
    out_valid_d   = out_valid;
    done_count_d  = done_count;
    pop           = 1'b0;

    case (state_q)
      RST_HI: state_d = RST_LO;
      RST_LO: state_d = IDLE;
      IDLE: begin
        if (!fifo_empty) begin
          pop           = 1'b1;
          op_a_d        = head.a;
          op_b_d        = head.b;
          input_a_d     = head.a;
          input_a_stb_d = 1'b1;
          state_d       = SEND_A;
        end
      end
      SEND_A: begin
        if (fadd_input_a_ack) begin
          input_b_d     = op_b_q;
          input_b_stb_d = 1'b1;
          state_d       = SEND_B;
        end else begin
          input_a_d     = op_a_q;
          input_a_stb_d = 1'b1;
        end
      end
      SEND_B: begin
        if (fadd_input_b_ack) begin
          state_d = WAIT_Z;
        end else begin
          input_b_d     = op_b_q;
          input_b_stb_d = 1'b1;
        end
      end
      WAIT_Z: begin
        if (z_take) state_d = IDLE;
      end
      default: state_d = RST_HI;
    endcase

    if (z_take) begin
      out_z_d     = fadd_output_z;
      out_valid_d = 1'b1;
    end else if (drain) begin
      out_valid_d = 1'b0;
    end

    if (drain) done_count_d = done_count + DONE_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= RST_HI;
      op_a_q           <= '0;
      op_b_q           <= '0;
      fadd_rst         <= 1'b1;
      fadd_input_a     <= '0;
      fadd_input_a_stb <= 1'b0;
      fadd_input_b     <= '0;
      fadd_input_b_stb <= 1'b0;
      out_z            <= '0;
      out_valid        <= 1'b0;
      done_count       <= '0;
    end else begin
      state_q          <= state_d;
      op_a_q           <= op_a_d;
      op_b_q           <= op_b_d;
      fadd_rst         <= fadd_rst_d;
      fadd_input_a     <= input_a_d;
      fadd_input_a_stb <= input_a_stb_d;
      fadd_input_b     <= input_b_d;
      fadd_input_b_stb <= input_b_stb_d;
      out_z            <= out_z_d;
      out_valid        <= out_valid_d;
      done_count       <= done_count_d;
    end
  end

endmodule

// File: tb/tb_fadd_stream_driver.sv
// Scoreboard bench for fadd_stream_driver with a behavioural strobe/ack adder core.
module tb_fadd_stream_driver;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] in_a, in_b;
  logic        in_valid, in_ready;
  logic [31:0] out_z;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        fadd_rst;
  logic [31:0] fadd_input_a, fadd_input_b;
  logic        fadd_input_a_stb, fadd_input_b_stb;
  logic        fadd_input_a_ack = 1'b0;
  logic        fadd_input_b_ack = 1'b0;
  logic [31:0] fadd_output_z = '0;
  logic        fadd_output_z_stb = 1'b0;
  logic        fadd_output_z_ack;
  logic        busy;
  logic [15:0] done_count;

  int          n_vec = 0;
  int          n_miss = 0;
  logic [31:0] exp_q[$];
  int          tb_done = 0;
  bit          hold_out = 1'b1;
  bit          rand_bp = 1'b0;
  int          a_delay = 0, b_delay = 0, z_delay = 0;
  int          a_cnt = 0, b_cnt = 0, z_cnt = 0;
  logic [31:0] got_a = '0, got_b = '0;
  bit          z_pend = 1'b0;
  logic        z_taken_q = 1'b0;

  always #5 clk = ~clk;

  fadd_stream_driver #(.FIFO_DEPTH(4)) dut (
    .clk               (clk),
    .rst               (rst),
    .in_a              (in_a),
    .in_b              (in_b),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .out_z             (out_z),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .fadd_rst          (fadd_rst),
    .fadd_input_a      (fadd_input_a),
    .fadd_input_a_stb  (fadd_input_a_stb),
    .fadd_input_a_ack  (fadd_input_a_ack),
    .fadd_input_b      (fadd_input_b),
    .fadd_input_b_stb  (fadd_input_b_stb),
    .fadd_input_b_ack  (fadd_input_b_ack),
    .fadd_output_z     (fadd_output_z),
    .fadd_output_z_stb (fadd_output_z_stb),
    .fadd_output_z_ack (fadd_output_z_ack),
    .busy              (busy),
    .done_count        (done_count)
  );

  // Stand-in adder: exact for 1.0+2.0, an asymmetric mix otherwise so swaps show up.
  function automatic logic [31:0] core_fn(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h3F80_0000 && b == 32'h4000_0000) return 32'h4040_0000;
    return (a ^ {b[15:0], b[31:16]}) + 32'h0000_1357;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Offer a pair from the next falling edge and return just after the accepting edge.
  task automatic push_pair(input logic [31:0] a, input logic [31:0] b, input bit last);
    int n = 0;
    @(negedge clk);
    in_a = a; in_b = b; in_valid = 1'b1;
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("push_ready", 32'(in_ready), 32'd1);
    if (in_ready) exp_q.push_back(core_fn(a, b));
    @(posedge clk);
    #1;
    if (last) in_valid = 1'b0;
  endtask

  task automatic drain_all();
    int n = 0;
    while (exp_q.size() != 0 && n < 600) begin
      @(negedge clk);
      n++;
    end
    check("drain_left", 32'(exp_q.size()), 32'd0);
  endtask

  always @(posedge clk) z_taken_q <= fadd_output_z_stb && fadd_output_z_ack;

  // Adder core responder, driven on the falling edge.
  always @(negedge clk) begin
    if (rst || fadd_rst) begin
      fadd_input_a_ack = 1'b0; fadd_input_b_ack = 1'b0;
      fadd_output_z_stb = 1'b0; fadd_output_z = '0;
      a_cnt = 0; b_cnt = 0; z_cnt = 0; z_pend = 1'b0;
    end else begin
      if (z_taken_q) begin
        fadd_output_z_stb = 1'b0;
        fadd_output_z = '0;
      end
      if (z_pend) begin
        if (z_cnt >= z_delay) begin
          fadd_output_z_stb = 1'b1;
          fadd_output_z = core_fn(got_a, got_b);
          z_pend = 1'b0; z_cnt = 0;
        end else z_cnt++;
      end
      fadd_input_a_ack = 1'b0;
      if (fadd_input_a_stb) begin
        if (a_cnt >= a_delay) begin
          fadd_input_a_ack = 1'b1; got_a = fadd_input_a; a_cnt = 0;
        end else a_cnt++;
      end
      fadd_input_b_ack = 1'b0;
      if (fadd_input_b_stb) begin
        if (b_cnt >= b_delay) begin
          fadd_input_b_ack = 1'b1; got_b = fadd_input_b; b_cnt = 0; z_pend = 1'b1;
        end else b_cnt++;
      end
    end
  end

  // Consumer and scoreboard: out_ready is chosen here so the handshake seen is the one clocked.
  always @(negedge clk) begin
    if (rst) out_ready = 1'b0;
    else out_ready = hold_out ? 1'b0 : (rand_bp ? ($urandom_range(0, 2) != 0) : 1'b1);
    if (!rst && out_valid && out_ready) begin
      check("out_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) check("out_z", out_z, exp_q.pop_front());
      tb_done++;
    end
  end

  initial begin
    #300000;
    n_miss++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] pa[6];
    logic [31:0] pb[6];
    int n;
    int cycles;
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_fadd_rst", 32'(fadd_rst), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_z", out_z, 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_done", 32'(done_count), 32'd0);
    check("rst_a_stb", 32'(fadd_input_a_stb), 32'd0);
    check("rst_a_data", fadd_input_a, 32'd0);
    check("rst_z_ack", 32'(fadd_output_z_ack), 32'd0);
    rst = 1'b0;
    #1;
    check("rsthi_fadd_rst", 32'(fadd_rst), 32'd1);
    check("rsthi_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    check("rstlo_fadd_rst", 32'(fadd_rst), 32'd0);
    check("rstlo_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    check("idle_in_ready", 32'(in_ready), 32'd1);
    check("idle_busy", 32'(busy), 32'd0);

    // 1.0 + 2.0 with an immediate core: result visible after the fourth edge past the push edge.
    hold_out = 1'b0;
    push_pair(32'h3F80_0000, 32'h4000_0000, 1'b1);
    repeat (4) @(negedge clk);
    check("lat_early_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("lat_valid", 32'(out_valid), 32'd1);
    check("lat_out_z", out_z, 32'h4040_0000);
    @(negedge clk);
    check("done_one", 32'(done_count), 32'd1);

    // B acknowledge held off 7 cycles: B strobe holds 8 cycles with stable data, A strobe idle.
    b_delay = 7;
    push_pair(32'h1122_3344, 32'h5566_7788, 1'b1);
    n = 0;
    while (!fadd_input_b_stb && n < 20) begin
      @(negedge clk);
      n++;
    end
    cycles = 0;
    while (fadd_input_b_stb && cycles < 30) begin
      check("b_data_stable", fadd_input_b, 32'h5566_7788);
      check("a_stb_idle", 32'(fadd_input_a_stb), 32'd0);
      cycles++;
      @(negedge clk);
    end
    check("b_stb_cycles", 32'(cycles), 32'd8);
    b_delay = 0;
    drain_all();

    // Core stalled on A: four pairs fill the FIFO, the fifth waits, all six finish in order.
    for (int i = 0; i < 6; i++) begin
      pa[i] = $urandom; pb[i] = $urandom;
    end
    a_delay = 40;
    push_pair(pa[0], pb[0], 1'b1);
    n = 0;
    while (!fadd_input_a_stb && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("stall_busy", 32'(busy), 32'd1);
    for (int i = 1; i < 5; i++) push_pair(pa[i], pb[i], 1'b0);
    @(negedge clk);
    in_a = pa[5]; in_b = pb[5];
    check("full_in_ready", 32'(in_ready), 32'd0);
    repeat (3) begin
      @(negedge clk);
      check("full_held", 32'(in_ready), 32'd0);
    end
    a_delay = 0;
    push_pair(pa[5], pb[5], 1'b1);
    rand_bp = 1'b1;
    drain_all();
    rand_bp = 1'b0;

    // Output blocked with a second result waiting: no ack until the consumer drains.
    @(posedge clk);
    #1 hold_out = 1'b1;
    push_pair(32'hAAAA_0001, 32'h0F0F_1234, 1'b0);
    push_pair(32'h4120_0000, 32'hC2C8_0000, 1'b1);
    n = 0;
    while (!(out_valid && fadd_output_z_stb) && n < 60) begin
      @(negedge clk);
      n++;
    end
    repeat (3) begin
      @(negedge clk);
      check("blocked_z_ack", 32'(fadd_output_z_ack), 32'd0);
      check("blocked_out_z", out_z, core_fn(32'hAAAA_0001, 32'h0F0F_1234));
      check("blocked_valid", 32'(out_valid), 32'd1);
    end
    @(posedge clk);
    #1 hold_out = 1'b0;
    @(negedge clk);
    #1;
    check("drain_z_ack", 32'(fadd_output_z_ack), 32'd1);
    @(negedge clk);
    check("reload_out_z", out_z, core_fn(32'h4120_0000, 32'hC2C8_0000));
    check("reload_valid", 32'(out_valid), 32'd1);
    drain_all();
    @(negedge clk);
    check("done_track", 32'(done_count), 32'(tb_done));

    // Reset in WAIT_Z with two pairs queued: everything discarded, reset sequence replayed.
    z_delay = 50;
    push_pair(32'h0000_1111, 32'h2222_0000, 1'b0);
    push_pair(32'h0000_3333, 32'h4444_0000, 1'b0);
    push_pair(32'h0000_5555, 32'h6666_0000, 1'b1);
    repeat (6) @(negedge clk);
    check("waitz_busy", 32'(busy), 32'd1);
    check("waitz_no_valid", 32'(out_valid), 32'd0);
    @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    exp_q.delete();
    tb_done = 0;
    check("mid_rst_fadd_rst", 32'(fadd_rst), 32'd1);
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_done", 32'(done_count), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd0);
    rst = 1'b0;
    z_delay = 0;
    repeat (2) @(negedge clk);
    check("post_rst_busy", 32'(busy), 32'd0);
    check("post_rst_valid", 32'(out_valid), 32'd0);
    repeat (10) @(negedge clk);
    check("no_stale_valid", 32'(out_valid), 32'd0);
    push_pair(32'h3F80_0000, 32'h4000_0000, 1'b1);
    drain_all();
    @(negedge clk);
    check("post_rst_done", 32'(done_count), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
